// File: rtl/sprite_layer_mixer.sv
// sprite_layer_mixer: picks the visible sprite/background pixel by fixed layer
// priority, blanks outside active video, and delays hsync/vsync/de to match.
// It also collects player-vs-enemy overlap per frame and reports it at each frame boundary.
// Latency: 2 clk cycles for rgb/hs/vs/de; collision report lands with the first active vga_vs_o.
// Backpressure: none; one pixel is accepted every clock.
// Ports: clk/rst (sync, active-high); de_i/hsync_i/vsync_i timing in;
//        layer_alpha_i/layer_rgb_i/bg_rgb_i pixel sources; vga_* delayed video out;
//        collide_o/frame_done_o/hit_frames_o per-frame collision report.
module sprite_layer_mixer #(
    parameter int N_LAYER  = 4,
    parameter int RGB_W    = 12,
    parameter int SYNC_POL = 0,
    // Derived width of collide_o; held at 1 (tied low) when there are no enemy layers.
    parameter int COLL_W   = (N_LAYER > 1) ? N_LAYER - 1 : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     de_i,
    input  logic                     hsync_i,
    input  logic                     vsync_i,
    input  logic [N_LAYER-1:0]       layer_alpha_i,
    input  logic [N_LAYER*RGB_W-1:0] layer_rgb_i,
    input  logic [RGB_W-1:0]         bg_rgb_i,
    output logic [RGB_W-1:0]         vga_rgb_o,
    output logic                     vga_hs_o,
    output logic                     vga_vs_o,
    output logic                     vga_de_o,
    output logic [COLL_W-1:0]        collide_o,
    output logic                     frame_done_o,
    output logic [7:0]               hit_frames_o
);

    localparam logic SYNC_ACT = (SYNC_POL != 0);

    logic [RGB_W-1:0] pick;
    logic [RGB_W-1:0] sel_s1;
    logic             hs_s1;
    logic             vs_s1;
    logic             de_s1;
    logic             s1_live;
    logic             prev_vs;
    logic             frame_evt;

    // Walk from the lowest-priority layer upward so the lowest opaque index wins.
    always_comb begin
        pick = bg_rgb_i;
        for (int k = N_LAYER - 1; k >= 0; k--) begin
            if (layer_alpha_i[k]) begin
                pick = layer_rgb_i[k*RGB_W +: RGB_W];
            end
        end
    end

    // Frame boundary: stage-1 vsync has just become active.
    assign frame_evt = (vs_s1 == SYNC_ACT) && (prev_vs != SYNC_ACT);

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_s1       <= '0;
            hs_s1        <= ~SYNC_ACT;
            vs_s1        <= ~SYNC_ACT;
            de_s1        <= 1'b0;
            s1_live      <= 1'b0;
            prev_vs      <= SYNC_ACT;
            vga_rgb_o    <= '0;
            vga_hs_o     <= ~SYNC_ACT;
            vga_vs_o     <= ~SYNC_ACT;
            vga_de_o     <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            sel_s1       <= pick;
            hs_s1        <= hsync_i;
            vs_s1        <= vsync_i;
            de_s1        <= de_i;
            s1_live      <= 1'b1;
            // The stage-1 reset fill is not a real sync sample; keep prev_vs at the
            // active level until stage 1 carries live data, so a vsync already
            // active across reset release does not look like a new boundary.
            prev_vs      <= s1_live ? vs_s1 : SYNC_ACT;
            vga_rgb_o    <= de_s1 ? sel_s1 : '0;
            vga_hs_o     <= hs_s1;
            vga_vs_o     <= vs_s1;
            vga_de_o     <= de_s1;
            frame_done_o <= frame_evt;
        end
    end

    generate
        if (N_LAYER > 1) begin : g_coll
            logic [N_LAYER-2:0] ov_s1;
            logic [N_LAYER-2:0] acc;
            logic [N_LAYER-2:0] frame_hits;

            // Overlap in the boundary cycle itself still belongs to the ending frame.
            assign frame_hits = acc | ov_s1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ov_s1        <= '0;
                    acc          <= '0;
                    collide_o    <= '0;
                    hit_frames_o <= 8'd0;
                end else begin
                    // Only player-vs-enemy overlap inside active video counts.
                    ov_s1 <= (de_i && layer_alpha_i[0]) ? layer_alpha_i[N_LAYER-1:1] : '0;
                    acc   <= frame_evt ? '0 : frame_hits;
                    if (frame_evt) begin
                        collide_o <= frame_hits;
                        if ((|frame_hits) && (hit_frames_o != 8'hFF)) begin
                            hit_frames_o <= hit_frames_o + 8'd1;
                        end
                    end
                end
            end
        end else begin : g_no_coll
            assign collide_o    = '0;
            assign hit_frames_o = 8'd0;
        end
    endgenerate

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Self-checking bench for sprite_layer_mixer with a frame-level reference model.
module tb_sprite_layer_mixer;

    logic        clk;
    logic        rst;
    logic        de_i;
    logic        hsync_i;
    logic        vsync_i;
    logic [3:0]  layer_alpha_i;
    logic [47:0] layer_rgb_i;
    logic [11:0] bg_rgb_i;
    logic [11:0] vga_rgb_o;
    logic        vga_hs_o;
    logic        vga_vs_o;
    logic        vga_de_o;
    logic [2:0]  collide_o;
    logic        frame_done_o;
    logic [7:0]  hit_frames_o;

    int checks = 0;
    int errors = 0;

    sprite_layer_mixer #(.N_LAYER(4), .RGB_W(12), .SYNC_POL(0)) dut (
        .clk(clk), .rst(rst), .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .layer_alpha_i(layer_alpha_i), .layer_rgb_i(layer_rgb_i), .bg_rgb_i(bg_rgb_i),
        .vga_rgb_o(vga_rgb_o), .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o), .vga_de_o(vga_de_o),
        .collide_o(collide_o), .frame_done_o(frame_done_o), .hit_frames_o(hit_frames_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs visible after a given clock edge.
    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fd;
        logic [2:0]  col;
        logic [7:0]  hits;
    } exp_t;

    localparam exp_t RST_EXP = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, de: 1'b0,
                                 fd: 1'b0, col: 3'b000, hits: 8'd0};

    // Reference model state: one frame's collected enemy overlaps, the last
    // reported set, the hit-frame tally and the previous vsync input level.
    logic [2:0] m_acc;
    logic [2:0] m_col;
    int         m_hits;
    logic       m_prev_vs;
    exp_t       pend;
    exp_t       ex;

    // Drive one pixel, predict its outputs, clock it in and return #1 after the edge.
    // After the edge that samples input j, the outputs reflect input j-1.
    task automatic cyc(input logic r, input logic d, input logic h, input logic v,
                       input logic [3:0] a, input logic [47:0] lr, input logic [11:0] b);
        exp_t       nx;
        logic [2:0] ov;
        logic       found;
        rst = r; de_i = d; hsync_i = h; vsync_i = v;
        layer_alpha_i = a; layer_rgb_i = lr; bg_rgb_i = b;
        if (r) begin
            ex = RST_EXP; pend = RST_EXP;
            m_acc = 3'b000; m_col = 3'b000; m_hits = 0; m_prev_vs = 1'b0;
        end else begin
            ex = pend;
            nx = RST_EXP;
            nx.rgb = 12'h000;
            if (d) begin
                found = 1'b0;
                nx.rgb = b;
                for (int k = 0; k < 4; k++) begin
                    if (!found && a[k]) begin
                        nx.rgb = lr[k*12 +: 12];
                        found = 1'b1;
                    end
                end
            end
            ov = (d && a[0]) ? a[3:1] : 3'b000;
            if (v == 1'b0 && m_prev_vs == 1'b1) begin
                m_col = m_acc | ov;
                if (m_col != 3'b000 && m_hits < 255) m_hits++;
                m_acc = 3'b000;
                nx.fd = 1'b1;
            end else begin
                m_acc = m_acc | ov;
                nx.fd = 1'b0;
            end
            m_prev_vs = v;
            nx.hs = h; nx.vs = v; nx.de = d;
            nx.col = m_col; nx.hits = m_hits[7:0];
            pend = nx;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, {4{12'hABC}}, 12'h123);
        end
        checks++;
        if (vga_rgb_o !== 12'h000 || vga_de_o !== 1'b0 || frame_done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_video: rgb=%h de=%b fd=%b, want 000/0/0", vga_rgb_o, vga_de_o, frame_done_o);
        end
        checks++;
        if (vga_hs_o !== 1'b1 || vga_vs_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_sync: hs=%b vs=%b, want 1/1", vga_hs_o, vga_vs_o);
        end
        checks++;
        if (collide_o !== 3'b000 || hit_frames_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_coll: collide=%b hits=%0d, want 000/0", collide_o, hit_frames_o);
        end
    endtask

    task automatic test_priority();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, {12'h000, 12'h0F0, 12'hF00, 12'h000}, 12'h00F);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, {12'h000, 12'h0F0, 12'hF00, 12'h000}, 12'h00F);
        checks++;
        if (vga_rgb_o !== 12'hF00) begin
            errors++;
            $display("FAIL priority_l1: rgb=%h, want F00", vga_rgb_o);
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, {12'h777, 12'h0F0, 12'hF00, 12'h000}, 12'h00F);
        checks++;
        if (vga_rgb_o !== 12'h00F) begin
            errors++;
            $display("FAIL priority_bg: rgb=%h, want 00F", vga_rgb_o);
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 48'h0, 12'h000);
        checks++;
        if (vga_rgb_o !== 12'h777) begin
            errors++;
            $display("FAIL priority_l3: rgb=%h, want 777", vga_rgb_o);
        end
    endtask

    task automatic test_blanking();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, {36'h0, 12'hFFF}, 12'h0AA);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 48'h0, 12'h000);
        checks++;
        if (vga_rgb_o !== 12'h000) begin
            errors++;
            $display("FAIL blank_rgb: rgb=%h, want 000", vga_rgb_o);
        end
        // hsync pulse and de rise together in cycle t.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 48'h0, 12'h5A5);
        checks++;
        if (vga_hs_o !== 1'b1 || vga_de_o !== 1'b0) begin
            errors++;
            $display("FAIL align_early: hs=%b de=%b, want 1/0", vga_hs_o, vga_de_o);
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 48'h0, 12'h5A5);
        checks++;
        if (vga_hs_o !== 1'b0 || vga_de_o !== 1'b1 || vga_rgb_o !== 12'h5A5) begin
            errors++;
            $display("FAIL align_at: hs=%b de=%b rgb=%h, want 0/1/5A5", vga_hs_o, vga_de_o, vga_rgb_o);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 48'h0, 12'h000);
        checks++;
        if (vga_hs_o !== 1'b1) begin
            errors++;
            $display("FAIL align_after: hs=%b, want 1", vga_hs_o);
        end
    endtask

    task automatic test_collision();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0101, 48'h0, 12'h000);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 48'h0, 12'h000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
        checks++;
        if (frame_done_o !== 1'b0 || vga_vs_o !== 1'b1) begin
            errors++;
            $display("FAIL coll_pre: fd=%b vs=%b, want 0/1", frame_done_o, vga_vs_o);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
        checks++;
        if (frame_done_o !== 1'b1 || vga_vs_o !== 1'b0 || collide_o !== 3'b010 || hit_frames_o !== 8'd1) begin
            errors++;
            $display("FAIL coll_report: fd=%b vs=%b collide=%b hits=%0d, want 1/0/010/1",
                     frame_done_o, vga_vs_o, collide_o, hit_frames_o);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
        checks++;
        if (frame_done_o !== 1'b0 || collide_o !== 3'b010) begin
            errors++;
            $display("FAIL coll_pulse: fd=%b collide=%b, want 0/010", frame_done_o, collide_o);
        end
        // Next frame without overlap.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 48'h0, 12'h000);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1110, 48'h0, 12'h000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
        checks++;
        if (frame_done_o !== 1'b1 || collide_o !== 3'b000 || hit_frames_o !== 8'd1) begin
            errors++;
            $display("FAIL coll_clear: fd=%b collide=%b hits=%0d, want 1/000/1", frame_done_o, collide_o, hit_frames_o);
        end
    endtask

    task automatic test_non_counting();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b0101, 48'h0, 12'h000);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 48'h0, 12'h000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
        checks++;
        if (frame_done_o !== 1'b1 || collide_o !== 3'b000 || hit_frames_o !== 8'd1) begin
            errors++;
            $display("FAIL noncount: fd=%b collide=%b hits=%0d, want 1/000/1", frame_done_o, collide_o, hit_frames_o);
        end
    endtask

    task automatic test_reset_midframe();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1001, 48'h0, 12'h000);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 48'h0, 12'h000);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b1001, 48'h0, 12'h000);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b1001, 48'h0, 12'h000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
        checks++;
        if (collide_o !== 3'b000 || hit_frames_o !== 8'd0 || vga_vs_o !== 1'b1 || frame_done_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: collide=%b hits=%0d vs=%b fd=%b, want 000/0/1/0",
                     collide_o, hit_frames_o, vga_vs_o, frame_done_o);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
            checks++;
            if (frame_done_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_noboundary: cycle %0d fd=%b, want 0", i, frame_done_o);
            end
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 48'h0, 12'h000);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 48'h0, 12'h000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
        checks++;
        if (frame_done_o !== 1'b1 || collide_o !== 3'b000 || hit_frames_o !== 8'd0) begin
            errors++;
            $display("FAIL rst_next: fd=%b collide=%b hits=%0d, want 1/000/0", frame_done_o, collide_o, hit_frames_o);
        end
    endtask

    task automatic test_saturation();
        int want;
        for (int f = 0; f < 260; f++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1001, 48'h0, 12'h000);
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 48'h0, 12'h000);
            want = (f < 255) ? f + 1 : 255;
            checks++;
            if (frame_done_o !== 1'b1 || collide_o !== 3'b100 || hit_frames_o !== want[7:0]) begin
                errors++;
                $display("FAIL saturate: frame %0d fd=%b collide=%b hits=%0d, want 1/100/%0d",
                         f, frame_done_o, collide_o, hit_frames_o, want);
            end
        end
    endtask

    task automatic test_random();
        logic r;
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            cyc(r, 1'($urandom), 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 11) != 0),
                4'($urandom), {$urandom, 16'($urandom)}, 12'($urandom));
            checks++;
            if (vga_rgb_o !== ex.rgb || vga_hs_o !== ex.hs || vga_vs_o !== ex.vs || vga_de_o !== ex.de) begin
                errors++;
                $display("FAIL rand_video: cyc %0d rgb=%h hs=%b vs=%b de=%b, want %h/%b/%b/%b",
                         i, vga_rgb_o, vga_hs_o, vga_vs_o, vga_de_o, ex.rgb, ex.hs, ex.vs, ex.de);
            end
            checks++;
            if (frame_done_o !== ex.fd || collide_o !== ex.col || hit_frames_o !== ex.hits) begin
                errors++;
                $display("FAIL rand_coll: cyc %0d fd=%b collide=%b hits=%0d, want %b/%b/%0d",
                         i, frame_done_o, collide_o, hit_frames_o, ex.fd, ex.col, ex.hits);
            end
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_blanking();
        test_collision();
        test_non_counting();
        test_reset_midframe();
        test_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
